// File: rtl/shift_capture.sv
// Loopback monitor for the 74HC595 display chain. Rebuilds each latched word from the pins,
// decodes it into a per-row image store, and exposes the store and error counters over Wishbone.
module shift_capture #(
  parameter int unsigned SHIFT_BITS  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_sr_clk,
  input  logic                  i_sr_latch,
  input  logic                  i_sr_mosi,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [3:0]            i_wb_addr,
  input  logic [3:0]            i_wb_sel,
  input  logic [31:0]           i_wb_wdata,
  output logic                  o_wb_ack,
  output logic                  o_wb_stall,
  output logic [31:0]           o_wb_rdata,
  output logic [SHIFT_BITS-1:0] o_word,
  output logic                  o_word_valid
);

  logic [SYNC_STAGES-1:0] sclk_sync, latch_sync, mosi_sync;
  logic                   sclk_prev, latch_prev;
  logic                   sclk_rise, latch_rise, mosi_bit;

  logic [SHIFT_BITS-1:0]  shreg;
  logic [5:0]             bitcnt;
  logic [15:0]            frame_cnt;
  logic [7:0]             len_err_cnt, row_err_cnt;
  logic [23:0]            row_store [8];

  logic [7:0]             row_field;
  logic [23:0]            rgb_field;
  logic                   row_onehot;
  logic [2:0]             row_idx;

  logic                   wb_req, wb_wr8;
  logic [31:0]            rd_data;

  // Write data carries no information; only the byte selects matter on a write.
  logic                   unused_wdata;
  assign unused_wdata = ^i_wb_wdata;

  assign o_wb_stall = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync  <= '0;
      latch_sync <= '0;
      mosi_sync  <= '0;
      sclk_prev  <= 1'b0;
      latch_prev <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], i_sr_clk};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], i_sr_latch};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], i_sr_mosi};
      sclk_prev  <= sclk_sync[SYNC_STAGES-1];
      latch_prev <= latch_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise  = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign latch_rise = latch_sync[SYNC_STAGES-1] & ~latch_prev;
  assign mosi_bit   = mosi_sync[SYNC_STAGES-1];

  assign wb_req = i_wb_cyc & i_wb_stb;
  assign wb_wr8 = wb_req & i_wb_we & (i_wb_addr == 4'd8);

  // Shift path; a latch sampling shreg in the same cycle sees the pre-shift value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg        <= '0;
      bitcnt       <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
    end else begin
      o_word_valid <= latch_rise;
      if (latch_rise) begin
        o_word <= shreg;
      end
      if (sclk_rise) begin
        shreg <= {shreg[SHIFT_BITS-2:0], mosi_bit};
      end
      if (latch_rise) begin
        bitcnt <= sclk_rise ? 6'd1 : 6'd0;
      end else if (sclk_rise && bitcnt != 6'd63) begin
        bitcnt <= bitcnt + 6'd1;
      end
    end
  end

  // Clears from the bus take priority over same-cycle increments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      len_err_cnt <= '0;
    end else begin
      if (wb_wr8 && (i_wb_sel[3] || i_wb_sel[2])) begin
        frame_cnt <= '0;
      end else if (latch_rise) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (wb_wr8 && i_wb_sel[1]) begin
        len_err_cnt <= '0;
      end else if (latch_rise && bitcnt != 6'(SHIFT_BITS) && len_err_cnt != 8'hff) begin
        len_err_cnt <= len_err_cnt + 8'd1;
      end
    end
  end

  assign row_field = o_word[SHIFT_BITS-1 -: 8];
  assign rgb_field = o_word[SHIFT_BITS-9 -: 24];

  always_comb begin
    row_onehot = (row_field != 8'd0) && ((row_field & (row_field - 8'd1)) == 8'd0);
    row_idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (row_field[i]) row_idx = 3'(i);
    end
  end

  // Row decode runs on the cycle o_word_valid marks a fresh word; blanking (row 0) is silent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_err_cnt <= '0;
      for (int i = 0; i < 8; i++) row_store[i] <= '0;
    end else begin
      if (o_word_valid && row_onehot) begin
        row_store[row_idx] <= rgb_field;
      end
      if (wb_wr8 && i_wb_sel[0]) begin
        row_err_cnt <= '0;
      end else if (o_word_valid && !row_onehot && row_field != 8'd0 && row_err_cnt != 8'hff) begin
        row_err_cnt <= row_err_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (!i_wb_addr[3]) begin
      rd_data = {8'h00, row_store[i_wb_addr[2:0]]};
    end else if (i_wb_addr == 4'd8) begin
      rd_data = {frame_cnt, len_err_cnt, row_err_cnt};
    end else if (i_wb_addr == 4'd9) begin
      rd_data = 32'(o_word);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_wb_ack   <= 1'b0;
      o_wb_rdata <= '0;
    end else begin
      o_wb_ack   <= wb_req;
      o_wb_rdata <= (wb_req && !i_wb_we) ? rd_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_shift_capture.sv
// Bench for shift_capture: bit-banged pin stimulus, a reference model of the chain and counters,
// and scoreboards for latched words and Wishbone responses.
module tb_shift_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sr_clk, sr_latch, sr_mosi;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_addr, wb_sel;
  logic [31:0] wb_wdata;
  logic        wb_ack, wb_stall;
  logic [31:0] wb_rdata;
  logic [31:0] word;
  logic        word_valid;

  int n_tests = 0;
  int n_fail  = 0;

  shift_capture #(.SHIFT_BITS(32), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_sr_clk    (sr_clk),
    .i_sr_latch  (sr_latch),
    .i_sr_mosi   (sr_mosi),
    .i_wb_cyc    (wb_cyc),
    .i_wb_stb    (wb_stb),
    .i_wb_we     (wb_we),
    .i_wb_addr   (wb_addr),
    .i_wb_sel    (wb_sel),
    .i_wb_wdata  (wb_wdata),
    .o_wb_ack    (wb_ack),
    .o_wb_stall  (wb_stall),
    .o_wb_rdata  (wb_rdata),
    .o_word      (word),
    .o_word_valid(word_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          cyc;
    bit          we;
    logic [3:0]  addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } op_t;

  typedef struct {
    bit          ack;
    bit          chk;
    logic [3:0]  addr;
    logic [31:0] data;
  } resp_t;

  op_t         op_q[$];
  resp_t       resp_q[$];
  logic [31:0] word_q[$];

  // Reference model
  logic [31:0] m_sh;
  int          m_bits, m_frame, m_len, m_rowerr;
  logic [23:0] m_row [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sh = '0; m_bits = 0; m_frame = 0; m_len = 0; m_rowerr = 0;
    for (int i = 0; i < 8; i++) m_row[i] = '0;
  endtask

  task automatic model_shift(input logic b);
    m_sh = {m_sh[30:0], b};
    if (m_bits < 63) m_bits++;
  endtask

  task automatic model_latch();
    logic [7:0] r;
    word_q.push_back(m_sh);
    m_frame = (m_frame + 1) & 16'hffff;
    if (m_bits != 32 && m_len < 255) m_len++;
    m_bits = 0;
    r = m_sh[31:24];
    if (r != 0 && (r & (r - 8'd1)) == 0) begin
      for (int i = 0; i < 8; i++) if (r[i]) m_row[i] = m_sh[23:0];
    end else if (r != 0 && m_rowerr < 255) begin
      m_rowerr++;
    end
  endtask

  function automatic logic [31:0] m_addr8();
    return {m_frame[15:0], m_len[7:0], m_rowerr[7:0]};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    sr_mosi = b;
    cycles(4);
    sr_clk = 1'b1;
    model_shift(b);
    cycles(4);
    sr_clk = 1'b0;
  endtask

  task automatic shift_word(input logic [63:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) shift_bit(v[i]);
    cycles(4);
  endtask

  task automatic latch();
    sr_latch = 1'b1;
    model_latch();
    cycles(4);
    sr_latch = 1'b0;
    cycles(6);
  endtask

  // Final shift edge and latch edge land on the same clk edge.
  task automatic shift_and_latch(input logic b);
    sr_mosi = b;
    cycles(4);
    sr_clk   = 1'b1;
    sr_latch = 1'b1;
    model_latch();
    model_shift(b);
    cycles(4);
    sr_clk   = 1'b0;
    sr_latch = 1'b0;
    cycles(6);
  endtask

  task automatic push_op(input bit cyc, input bit we, input logic [3:0] addr,
                         input logic [3:0] sel, input bit chk, input logic [31:0] exp);
    op_t o;
    o.cyc = cyc; o.we = we; o.addr = addr; o.sel = sel; o.wdata = 32'hdead_beef;
    o.chk = chk; o.exp = exp;
    op_q.push_back(o);
  endtask

  // Strobes issued on consecutive cycles; the response to strobe i is sampled during cycle i+1.
  task automatic run_ops();
    int    n;
    resp_t r;
    n = op_q.size();
    for (int i = 0; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (i < n) begin
        wb_cyc = op_q[i].cyc; wb_stb = 1'b1; wb_we = op_q[i].we;
        wb_addr = op_q[i].addr; wb_sel = op_q[i].sel; wb_wdata = op_q[i].wdata;
        r.ack = op_q[i].cyc; r.chk = op_q[i].chk & ~op_q[i].we;
        r.addr = op_q[i].addr; r.data = op_q[i].exp;
        resp_q.push_back(r);
      end else begin
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      end
      @(negedge clk);
      check("wb_stall", {31'd0, wb_stall}, 32'd0);
      if (i > 0) begin
        r = resp_q.pop_front();
        check($sformatf("wb_ack[%0d]", i - 1), {31'd0, wb_ack}, {31'd0, r.ack});
        if (r.chk && r.ack) check($sformatf("wb_rdata addr %0d", r.addr), wb_rdata, r.data);
      end
    end
    @(negedge clk);
    check("wb_ack_idle", {31'd0, wb_ack}, 32'd0);
    op_q.delete();
  endtask

  task automatic read_all_rows();
    for (int r = 0; r < 8; r++) push_op(1'b1, 1'b0, 4'(r), 4'h0, 1'b1, {8'h00, m_row[r]});
    push_op(1'b1, 1'b0, 4'd8, 4'h0, 1'b1, m_addr8());
    push_op(1'b1, 1'b0, 4'd9, 4'h0, 1'b1, m_sh_last());
    run_ops();
  endtask

  logic [31:0] last_word;
  function automatic logic [31:0] m_sh_last();
    return last_word;
  endfunction

  // Word scoreboard: each o_word_valid pulse consumes one expected latched word.
  logic valid_d = 1'b0;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && word_valid === 1'b1) begin
      check("valid_width", {31'd0, valid_d}, 32'd0);
      if (word_q.size() == 0) begin
        check("valid_unexpected", {31'd0, word_valid}, 32'd0);
      end else begin
        check("o_word", word, word_q.pop_front());
      end
    end
    valid_d = word_valid;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; sr_clk = 1'b0; sr_latch = 1'b0; sr_mosi = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_sel = '0; wb_wdata = '0;
    model_reset();
    last_word = '0;
    cycles(3);
    @(negedge clk);
    check("rst_o_word", word, 32'd0);
    check("rst_valid", {31'd0, word_valid}, 32'd0);
    check("rst_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_rdata", wb_rdata, 32'd0);
    check("rst_stall", {31'd0, wb_stall}, 32'd0);
    reset_n = 1'b1;
    cycles(3);

    // 1: single word to row 2
    shift_word(64'h04AA550F, 32);
    latch();
    last_word = 32'h04AA550F;
    push_op(1'b1, 1'b0, 4'd2, 4'h0, 1'b1, 32'h00AA550F);
    push_op(1'b1, 1'b0, 4'd8, 4'h0, 1'b1, 32'h00010000);
    push_op(1'b1, 1'b0, 4'd9, 4'h0, 1'b1, 32'h04AA550F);
    push_op(1'b0, 1'b0, 4'd9, 4'h0, 1'b0, 32'h0);
    run_ops();

    // 2: full frame
    for (int r = 0; r < 8; r++) begin
      last_word = {8'(1 << r), 24'(r * 32'h111111)};
      shift_word({32'd0, last_word}, 32);
      latch();
    end
    for (int r = 0; r < 8; r++) push_op(1'b1, 1'b0, 4'(r), 4'h0, 1'b1, 32'(r * 32'h111111));
    push_op(1'b1, 1'b0, 4'd8, 4'h0, 1'b1, {16'd9, 8'd0, 8'd0});
    run_ops();

    // 3: short and long words, then a clean one
    shift_word(64'h0000_1234, 31);
    latch();
    shift_word(64'h0_0000_5678, 33);
    latch();
    last_word = 32'h00ABCDEF;
    shift_word({32'd0, last_word}, 32);
    latch();
    check("len_err_model", 32'(m_len), 32'd2);
    read_all_rows();

    // 4: two-hot row then blanking
    shift_word(64'h06FFFFFF, 32);
    latch();
    last_word = 32'h00123456;
    shift_word({32'd0, last_word}, 32);
    latch();
    read_all_rows();

    // 5: final shift edge coincides with latch
    shift_word(64'h80C0FFEE, 31);
    last_word = m_sh;
    shift_and_latch(1'b1);
    last_word = 32'h40102030;
    shift_word({32'd0, last_word}, 31);
    last_word = m_sh;
    latch();
    read_all_rows();

    // 6: clear error counters amid back-to-back reads
    push_op(1'b1, 1'b0, 4'd8, 4'h0, 1'b1, m_addr8());
    push_op(1'b1, 1'b1, 4'd8, 4'b0011, 1'b0, 32'h0);
    push_op(1'b1, 1'b0, 4'd8, 4'h0, 1'b1, {m_frame[15:0], 16'h0000});
    push_op(1'b1, 1'b0, 4'd9, 4'h0, 1'b1, last_word);
    run_ops();
    m_len = 0; m_rowerr = 0;

    // Reset mid-word with a strobe in flight
    shift_word(64'h3FF, 10);
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 4'd9;
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    check("rst_drop_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_mid_o_word", word, 32'd0);
    reset_n = 1'b1;
    model_reset();
    last_word = '0;
    cycles(2);
    read_all_rows();

    check("word_q_drained", 32'(word_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
